// File: rtl/pipe_pkg.sv
// Shared state encoding, width defaults and ex/mem control-bit positions for pipe_stage_reg.
// Latency: n/a (types only). Backpressure: n/a.
// Control word layout: {MemToReg, RegWrite, MemRead, MemWrite, Branch}, MSB first.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int DEF_DATA_W = 81;
  localparam int DEF_CTRL_W = 5;

  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_BRANCH     = 0;

  function automatic logic [1:0] state_occupancy(input stage_state_e s);
    case (s)
      HALF:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload+control entry register with load enable, cleared asynchronously by reset_n.
// Latency: one cycle from load to q. Backpressure: none (caller owns load).
// Holds its value whenever load is low.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else if (load) begin
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register (ex/mem), two entries with skid when PIPE_STAGE_SKID_EN is defined, one otherwise.
// Latency: one cycle from input transfer to out_valid; full throughput while out_ready is high.
// Backpressure: skid build has registered in_ready (low only when FULL); one-entry build uses in_ready = !out_valid || out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  stage_state_e      state, state_nxt;
  logic              out_valid_q;
  logic [1:0]        occupancy_q;
  logic              in_xfer, out_xfer;
  logic              head_load;
  logic [DATA_W-1:0] head_data, head_d_data;
  logic [CTRL_W-1:0] head_ctrl, head_d_ctrl;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q;
  logic              skid_load;
  logic              head_from_skid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign out_valid = out_valid_q;
  assign occupancy = occupancy_q;
  assign out_data  = head_data;
  // Bubbles must never carry live write enables downstream.
  assign out_ctrl  = out_valid_q ? head_ctrl : '0;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_nxt = state;
    head_load = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
`endif
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            head_load = 1'b1;
            state_nxt = HALF;
          end
        end
        HALF: begin
          if (in_xfer && out_xfer) begin
            head_load = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_xfer) begin
            skid_load = 1'b1;
            state_nxt = FULL;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          // in_ready is low here, so only the skid promotion can happen.
          if (out_xfer) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            state_nxt      = HALF;
          end
        end
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  assign head_d_data = head_from_skid ? skid_data : in_data;
  assign head_d_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
`else
  assign head_d_data = in_data;
  assign head_d_ctrl = in_ctrl;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q  <= 1'b1;
`endif
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt != EMPTY);
      occupancy_q <= state_occupancy(state_nxt);
`ifdef PIPE_STAGE_SKID_EN
      in_ready_q  <= (state_nxt != FULL);
`endif
    end
  end

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_head (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (head_load),
    .d_data  (head_d_data),
    .d_ctrl  (head_d_ctrl),
    .q_data  (head_data),
    .q_ctrl  (head_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (skid_load),
    .d_data  (in_data),
    .d_ctrl  (in_ctrl),
    .q_data  (skid_data),
    .q_ctrl  (skid_ctrl)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, checked against a queue model of the stage.
module tb_pipe_stage_reg;
  localparam int DATA_W = 81;
  localparam int CTRL_W = 5;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t q[$];
  logic [DATA_W-1:0] held = '0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_in_ready();
    if (CAP == 1) return (q.size() == 0) || out_ready;
    return q.size() < CAP;
  endfunction

  task automatic check_outputs();
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready",  128'(in_ready),  128'(exp_in_ready()));
    chk("out_data",  128'(out_data),  128'((q.size() > 0) ? q[0].d : held));
    chk("out_ctrl",  128'(out_ctrl),  128'((q.size() > 0) ? q[0].c : '0));
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
  endtask

  // Check settled outputs, then apply the edge to the model.
  task automatic tick();
    logic irdy, ox, ix;
    #2;
    check_outputs();
    irdy = exp_in_ready();
    ox   = (q.size() > 0) && out_ready;
    ix   = in_valid && irdy;
    @(posedge clock);
    if (flush) q.delete();
    else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back('{c: in_ctrl, d: in_data});
    end
    if (q.size() > 0) held = q[0].d;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    q.delete();
    held = '0;
    #1;
    check_outputs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    ent_t e;
    reset_n = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #3;
    do_reset();

    // Single transfer then bubble.
    drive(1'b1, 81'h1_2345_6789, 5'b01010, 1'b1, 1'b0);
    tick();
    chk("req32_valid", 128'(out_valid), 128'(1));
    chk("req32_data",  128'(out_data),  128'(81'h1_2345_6789));
    chk("req32_ctrl",  128'(out_ctrl),  128'(5'b01010));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("req32_bubble_valid", 128'(out_valid), 128'(0));
    chk("req32_bubble_ctrl",  128'(out_ctrl),  128'(0));
    chk("req32_hold_data",    128'(out_data),  128'(81'h1_2345_6789));

    // Back-to-back stream.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0);
      tick();
      chk("stream_data", 128'(out_data), 128'(i));
      chk("stream_occ",  128'(occupancy), 128'(1));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();

    // Stall with two sends, then drain.
    drive(1'b1, 81'hA, 5'b00011, 1'b0, 1'b0); tick();
    drive(1'b1, 81'hB, 5'b00101, 1'b0, 1'b0); tick();
    chk("stall_occ",    128'(occupancy), 128'(CAP));
    chk("stall_in_rdy", 128'(in_ready),  128'(CAP == 1 ? 0 : 0));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Fill, then flush together with a new input that must vanish.
    drive(1'b1, 81'hA, 5'b00001, 1'b0, 1'b0); tick();
    drive(1'b1, 81'hB, 5'b00010, 1'b0, 1'b0); tick();
    drive(1'b1, 81'hC, 5'b11111, 1'b1, 1'b1); tick();
    chk("flush_occ",   128'(occupancy), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("flush_no_c", 128'(out_data == 81'hC), 128'(0));
    end

    // Asynchronous reset in the middle of a cycle while loaded.
    drive(1'b1, 81'h55, 5'b10101, 1'b0, 1'b0); tick();
    drive(1'b1, 81'h66, 5'b01011, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    q.delete();
    held = '0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_ctrl",  128'(out_ctrl),  128'(0));
    chk("arst_occ",   128'(occupancy), 128'(0));
    check_outputs();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 81'h77, 5'b00100, 1'b1, 1'b0);
    tick();
    chk("post_reset_accept", 128'(out_data), 128'(81'h77));

    // Hold out_ready low; toggle it mid-cycle to observe in_ready's dependence.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DATA_W'(100 + i), 5'b00001, 1'b0, 1'b0);
      #2;
      chk("hold_in_rdy_lo", 128'(in_ready), 128'(exp_in_ready()));
      out_ready = 1'b1;
      #1;
      chk("hold_in_rdy_hi", 128'(in_ready), 128'(exp_in_ready()));
      out_ready = 1'b0;
      tick();
      chk("hold_occ_max", 128'(occupancy <= 2'(CAP)), 128'(1));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      rd = DATA_W'({$urandom(), $urandom(), $urandom()});
      e.c = CTRL_W'($urandom());
      drive(1'($urandom_range(0, 3) != 0), rd, e.c,
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 24) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
